vga_controller: RTL

VGA_CONTROLLER -- requirements
Module: vga_controller

---
 rtl/vga_controller.sv | 109 ++++++++++
 1 files changed

// File: rtl/vga_controller.sv
// 640x480 VGA timing generator; define VGA_PIX_DIV_EN to run from a 2x clk with an internal divide-by-2.
// Outputs are registered one pixel tick behind the counters; free-running, no backpressure.
module vga_controller #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic       sync_n,
  output logic       vga_clk,
  output logic       frame_start
);

  localparam logic [9:0] H_MAX    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_MAX    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic       pix_en;
  logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       hsync_q, hsync_d, vsync_q, vsync_d;
  logic       blank_n_q, blank_n_d, frame_start_q, frame_start_d;

`ifdef VGA_PIX_DIV_EN
  logic toggle_q, toggle_d;

  always_comb toggle_d = ~toggle_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) toggle_q <= 1'b0;
    else        toggle_q <= toggle_d;
  end

  assign pix_en  = toggle_q;
  assign vga_clk = toggle_q;
`else
  assign pix_en  = 1'b1;
  assign vga_clk = clk;
`endif

  always_comb begin
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    x_d           = x_q;
    y_d           = y_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    blank_n_d     = blank_n_q;
    frame_start_d = 1'b0;
    if (pix_en) begin
      hcnt_d = (hcnt_q == H_MAX) ? 10'd0 : hcnt_q + 10'd1;
      if (hcnt_q == H_MAX) vcnt_d = (vcnt_q == V_MAX) ? 10'd0 : vcnt_q + 10'd1;
      // Everything shown this tick is decoded from the pre-increment counts.
      x_d           = hcnt_q;
      y_d           = vcnt_q;
      hsync_d       = !((hcnt_q >= HS_START) && (hcnt_q < HS_END));
      vsync_d       = !((vcnt_q >= VS_START) && (vcnt_q < VS_END));
      blank_n_d     = (hcnt_q < H_VIS) && (vcnt_q < V_VIS);
      frame_start_d = (hcnt_q == 10'd0) && (vcnt_q == 10'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q        <= 10'd0;
      vcnt_q        <= 10'd0;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      blank_n_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_n_q     <= blank_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank_n     = blank_n_q;
  assign frame_start = frame_start_q;
  assign sync_n      = 1'b0;

endmodule
